// File: rtl/ofifo_drain_if.sv
// Output-FIFO read port and psum SRAM write port seen by the drain controller.
// master = controller (pops FIFO, drives SRAM); slave = FIFO/SRAM side.
interface ofifo_drain_if #(
    parameter int col    = 8,
    parameter int bw     = 16,
    parameter int addr_w = 11
);
    logic                ofifo_valid;
    logic [bw*col-1:0]   ofifo_out;
    logic                ofifo_rd;
    logic                sram_cen;
    logic                sram_wen;
    logic [addr_w-1:0]   sram_addr;
    logic [bw*col-1:0]   sram_d;

    modport master (
        input  ofifo_valid, ofifo_out,
        output ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d
    );

    modport slave (
        output ofifo_valid, ofifo_out,
        input  ofifo_rd, sram_cen, sram_wen, sram_addr, sram_d
    );
endinterface

// File: rtl/ofifo_drain.sv
// Drains num_rows psum rows from the output FIFO into SRAM at base_addr onward.
// Ports: clk, reset (sync, active high), start/base_addr/num_rows command,
//   busy/done status, bus (ofifo_drain_if.master: FIFO pop + SRAM write).
// Optional: define OFIFO_DRAIN_RELU_EN to clamp negative lanes to zero.
module ofifo_drain #(
    parameter int col    = 8,
    parameter int bw     = 16,
    parameter int addr_w = 11
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [addr_w-1:0] base_addr,
    input  logic [addr_w-1:0] num_rows,
    output logic              busy,
    output logic              done,
    ofifo_drain_if.master     bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] POP  = 2'd1;
    localparam logic [1:0] WR   = 2'd2;
    localparam logic [1:0] FIN  = 2'd3;

    localparam logic [addr_w-1:0] ONE = addr_w'(1);

    logic [1:0]          state;
    logic [addr_w-1:0]   addr_cnt;
    logic [addr_w-1:0]   rem_cnt;
    logic [bw*col-1:0]   row_in;

    always_comb begin
        row_in = bus.ofifo_out;
`ifdef OFIFO_DRAIN_RELU_EN
        for (int i = 0; i < col; i++) begin
            if (bus.ofifo_out[bw*i+bw-1])
                row_in[bw*i +: bw] = '0;
        end
`else
`endif
    end

    // Pop is combinational so the FIFO sees it in the same cycle the
    // head row is captured; reset masks it so an aborted POP never pops.
    assign bus.ofifo_rd = (state == POP) && bus.ofifo_valid && !reset;
    assign busy = (state != IDLE);
    assign done = (state == FIN) && !reset;

    // The SRAM port registers double as the row data register: they are
    // loaded on the POP->WR edge, so cen/wen are low for exactly the WR cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            addr_cnt      <= '0;
            rem_cnt       <= '0;
            bus.sram_cen  <= 1'b1;
            bus.sram_wen  <= 1'b1;
            bus.sram_addr <= '0;
            bus.sram_d    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (num_rows != '0) begin
                            addr_cnt <= base_addr;
                            rem_cnt  <= num_rows;
                            state    <= POP;
                        end else begin
                            state    <= FIN;
                        end
                    end
                end
                POP: begin
                    if (bus.ofifo_valid) begin
                        bus.sram_d    <= row_in;
                        bus.sram_addr <= addr_cnt;
                        bus.sram_cen  <= 1'b0;
                        bus.sram_wen  <= 1'b0;
                        state         <= WR;
                    end
                end
                WR: begin
                    // One cycle here also hides the FIFO head-advance bubble.
                    bus.sram_cen <= 1'b1;
                    bus.sram_wen <= 1'b1;
                    addr_cnt     <= addr_cnt + ONE;
                    rem_cnt      <= rem_cnt - ONE;
                    state        <= (rem_cnt == ONE) ? FIN : POP;
                end
                FIN: begin
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ofifo_drain.sv
// Directed bench for ofifo_drain with a registered-pop FIFO model.
// Inputs change 1ns after posedge; outputs are checked 1ns after negedge.
module tb_ofifo_drain;
    localparam int COL = 8;
    localparam int BW  = 16;
    localparam int AW  = 11;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW-1:0] num_rows = '0;
    logic          busy;
    logic          done;

    ofifo_drain_if #(.col(COL), .bw(BW), .addr_w(AW)) bus ();

    ofifo_drain #(.col(COL), .bw(BW), .addr_w(AW)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .base_addr (base_addr),
        .num_rows  (num_rows),
        .busy      (busy),
        .done      (done),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    // FIFO model: rd is registered, head moves on the following edge.
    logic [127:0] fm [0:63];
    logic [5:0]   wp = '0;
    logic [5:0]   head = '0;
    logic         rd_q = 1'b0;
    logic         valid_en = 1'b0;

    assign bus.ofifo_valid = valid_en && (head != wp);
    assign bus.ofifo_out   = fm[head];

    always @(posedge clk) begin
        rd_q <= bus.ofifo_rd;
        if (rd_q) head <= head + 6'd1;
    end

    // Activity monitor.
    int           cyc = 0;
    int           wn = 0;
    int           rdn = 0;
    int           dn = 0;
    int           b2b = 0;
    int           last_wr = 0;
    int           last_done = 0;
    logic         rd_prev = 1'b0;
    logic [AW-1:0] wa [0:63];
    logic [127:0]  wd [0:63];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (!bus.sram_cen && !bus.sram_wen) begin
            if (wn < 64) begin
                wa[wn] = bus.sram_addr;
                wd[wn] = bus.sram_d;
            end
            wn = wn + 1;
            last_wr = cyc;
        end
        if (bus.ofifo_rd) begin
            rdn = rdn + 1;
            if (rd_prev) b2b = b2b + 1;
        end
        rd_prev = bus.ofifo_rd;
        if (done) begin
            dn = dn + 1;
            last_done = cyc;
        end
    end

    int total = 0;
    int bad = 0;

    task automatic chk(input string tag, input logic [127:0] obs,
                       input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic push(input logic [127:0] r);
        fm[wp] = r;
        wp = wp + 6'd1;
    endtask

    function automatic logic [127:0] mkrow(input int k);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < COL; i++)
            r[16*i +: 16] = 16'(k * 16'h0800 + i * 16'h0101 + 1);
        return r;
    endfunction

    // Issue start, then step until done (bounded). c = cycle of done, 1 = POP.
    task automatic run(input logic [AW-1:0] b, input logic [AW-1:0] n,
                       output int c);
        nxt();
        start = 1'b1;
        base_addr = b;
        num_rows = n;
        nxt();
        start = 1'b0;
        smp();
        c = 1;
        while (!done && c < 40) begin
            nxt();
            smp();
            c++;
        end
        chk("done_seen", {127'd0, done}, 128'd1);
    endtask

    int w0, r0, d0, c;
    logic [127:0] rr, ex;

    initial begin
        // Reset values
        reset = 1'b1;
        nxt();
        nxt();
        smp();
        chk("rst_cen", {127'd0, bus.sram_cen}, 128'd1);
        chk("rst_wen", {127'd0, bus.sram_wen}, 128'd1);
        chk("rst_addr", {117'd0, bus.sram_addr}, 128'd0);
        chk("rst_d", bus.sram_d, 128'd0);
        chk("rst_busy", {127'd0, busy}, 128'd0);
        chk("rst_done", {127'd0, done}, 128'd0);
        nxt();
        reset = 1'b0;
        smp();
        chk("rst_rd", {127'd0, bus.ofifo_rd}, 128'd0);

        // Continuous drain of 4 rows
        for (int k = 0; k < 4; k++) push(mkrow(k));
        valid_en = 1'b1;
        w0 = wn; r0 = rdn; d0 = dn;
        run(11'h010, 11'd4, c);
        chk("cont_cycles", 128'(c), 128'd9);
        nxt(); smp();
        nxt(); smp();
        chk("cont_nwr", 128'(wn - w0), 128'd4);
        for (int k = 0; k < 4; k++) begin
            chk("cont_addr", {117'd0, wa[w0+k]}, 128'(11'h010 + k));
            chk("cont_data", wd[w0+k], mkrow(k));
        end
        chk("cont_rd", 128'(rdn - r0), 128'd4);
        chk("cont_b2b", 128'(b2b), 128'd0);
        chk("cont_done_n", 128'(dn - d0), 128'd1);
        chk("cont_done_lat", 128'(last_done - last_wr), 128'd1);
        chk("cont_busy", {127'd0, busy}, 128'd0);

        // Stall: FIFO empty for 5 cycles after the first write
        push(mkrow(4));
        push(mkrow(5));
        w0 = wn;
        nxt();
        start = 1'b1; base_addr = 11'h040; num_rows = 11'd2;
        nxt();
        start = 1'b0;
        smp();
        chk("stl_rd1", {127'd0, bus.ofifo_rd}, 128'd1);
        nxt(); smp();
        chk("stl_wr1", {127'd0, bus.sram_cen}, 128'd0);
        chk("stl_a1", {117'd0, bus.sram_addr}, 128'h040);
        for (int i = 0; i < 5; i++) begin
            nxt();
            valid_en = 1'b0;
            smp();
            chk("stl_rd0", {127'd0, bus.ofifo_rd}, 128'd0);
            chk("stl_cen", {127'd0, bus.sram_cen}, 128'd1);
            chk("stl_busy", {127'd0, busy}, 128'd1);
        end
        nxt();
        valid_en = 1'b1;
        smp();
        chk("stl_rd2", {127'd0, bus.ofifo_rd}, 128'd1);
        chk("stl_cen2", {127'd0, bus.sram_cen}, 128'd1);
        nxt(); smp();
        chk("stl_wen2", {127'd0, bus.sram_wen}, 128'd0);
        chk("stl_a2", {117'd0, bus.sram_addr}, 128'h041);
        chk("stl_d2", bus.sram_d, mkrow(5));
        nxt(); smp();
        chk("stl_done", {127'd0, done}, 128'd1);
        chk("stl_nwr", 128'(wn - w0), 128'd2);

        // Zero rows
        nxt(); smp();
        w0 = wn; r0 = rdn; d0 = dn;
        nxt();
        start = 1'b1; base_addr = 11'h123; num_rows = 11'd0;
        nxt();
        start = 1'b0;
        smp();
        chk("zero_done", {127'd0, done}, 128'd1);
        chk("zero_rd", {127'd0, bus.ofifo_rd}, 128'd0);
        chk("zero_cen", {127'd0, bus.sram_cen}, 128'd1);
        nxt(); smp();
        chk("zero_done_off", {127'd0, done}, 128'd0);
        chk("zero_busy", {127'd0, busy}, 128'd0);
        chk("zero_nwr", 128'(wn - w0), 128'd0);
        chk("zero_nrd", 128'(rdn - r0), 128'd0);
        chk("zero_ndone", 128'(dn - d0), 128'd1);

        // Start while busy is ignored
        push(mkrow(6));
        push(mkrow(7));
        push(mkrow(8));
        w0 = wn; d0 = dn;
        nxt();
        start = 1'b1; base_addr = 11'h020; num_rows = 11'd2;
        nxt();
        start = 1'b1; base_addr = 11'h300; num_rows = 11'd5;
        nxt();
        start = 1'b0;
        c = 0;
        smp();
        while (!done && c < 40) begin
            nxt(); smp(); c++;
        end
        nxt(); smp();
        nxt(); smp();
        chk("ign_nwr", 128'(wn - w0), 128'd2);
        chk("ign_a0", {117'd0, wa[w0]}, 128'h020);
        chk("ign_a1", {117'd0, wa[w0+1]}, 128'h021);
        chk("ign_d1", wd[w0+1], mkrow(7));
        chk("ign_ndone", 128'(dn - d0), 128'd1);
        chk("ign_busy", {127'd0, busy}, 128'd0);

        // Address wrap; row 8 is still at the FIFO head
        push(mkrow(9));
        w0 = wn;
        run(11'h7FF, 11'd2, c);
        chk("wrap_cycles", 128'(c), 128'd5);
        chk("wrap_a0", {117'd0, wa[w0]}, 128'h7FF);
        chk("wrap_a1", {117'd0, wa[w0+1]}, 128'h000);
        chk("wrap_d0", wd[w0], mkrow(8));
        chk("wrap_d1", wd[w0+1], mkrow(9));

        // Signed lanes
        rr = {16'h0001, 16'hFFFE, 16'h0000, 16'h1234,
              16'h7FFF, 16'h8000, 16'h0005, 16'hFFFF};
`ifdef OFIFO_DRAIN_RELU_EN
        ex = {16'h0001, 16'h0000, 16'h0000, 16'h1234,
              16'h7FFF, 16'h0000, 16'h0005, 16'h0000};
`else
        ex = rr;
`endif
        push(rr);
        w0 = wn;
        run(11'h055, 11'd1, c);
        chk("relu_nwr", 128'(wn - w0), 128'd1);
        chk("relu_addr", {117'd0, wa[w0]}, 128'h055);
        chk("relu_data", wd[w0], ex);

        // Reset during the second WR
        nxt(); smp();
        push(mkrow(10));
        push(mkrow(11));
        push(mkrow(12));
        w0 = wn; d0 = dn;
        nxt();
        start = 1'b1; base_addr = 11'h010; num_rows = 11'd3;
        nxt();
        start = 1'b0;
        nxt();
        nxt();
        nxt();
        reset = 1'b1;
        smp();
        chk("mid_wr2", {127'd0, bus.sram_wen}, 128'd0);
        nxt();
        reset = 1'b0;
        smp();
        chk("mid_busy", {127'd0, busy}, 128'd0);
        chk("mid_cen", {127'd0, bus.sram_cen}, 128'd1);
        chk("mid_wen", {127'd0, bus.sram_wen}, 128'd1);
        chk("mid_addr", {117'd0, bus.sram_addr}, 128'd0);
        for (int i = 0; i < 4; i++) begin
            nxt(); smp();
        end
        chk("mid_nwr", 128'(wn - w0), 128'd2);
        chk("mid_ndone", 128'(dn - d0), 128'd0);
        w0 = wn;
        run(11'h000, 11'd1, c);
        chk("mid_new_cycles", 128'(c), 128'd3);
        chk("mid_new_nwr", 128'(wn - w0), 128'd1);
        chk("mid_new_addr", {117'd0, wa[w0]}, 128'h000);
        chk("mid_new_data", wd[w0], mkrow(12));

        nxt(); smp();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
